// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: opcodes, FSM state encoding and frame geometry.
package spi_pkg;

  // {cmd, din}
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned RX_W    = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StShift,
    StHold,
    StTurn,
    StRecv,
    StEnd
  } spi_state_e;

endpackage

// File: rtl/spi_if.sv
// SPI bus between master and slave.
//   SS_n : active-low slave select (master -> slave)
//   MOSI : serial data master -> slave
//   MISO : serial data slave -> master
interface spi_if;
  logic SS_n;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output MOSI, input MISO);
  modport slave  (input SS_n, input MOSI, output MISO);
endinterface

// File: rtl/spi_rx_shift.sv
// LSB-first MISO collector: each enabled cycle shifts miso_i in at the top, so after
// eight samples the k-th sample sits in bit k.
//   clk, rst : clock, synchronous active-high reset
//   en_i     : sample miso_i this cycle
//   clr_i    : clear the collected byte
//   miso_i   : serial input
//   data_o   : collected byte
module spi_rx_shift
  import spi_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            miso_i,
  output logic [RX_W-1:0] data_o
);

  logic [RX_W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = {miso_i, data_q[RX_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/spi_master.sv
// SPI master: sends a 10-bit {cmd, din} frame MSB first after a one-cycle command bit,
// and for read-data commands waits RD_TURN cycles then collects a byte from MISO.
//   clk, rst : single clock (also the SPI bit clock), synchronous active-high reset
//   start    : request a transaction (ignored while busy)
//   cmd, din : opcode and payload, latched on acceptance
//   busy     : transaction in progress (CMD through END)
//   done     : one-cycle completion pulse (END)
//   rd_data  : last byte read; rd_valid pulses with done on read-data frames
//   spi      : SS_n / MOSI / MISO bus
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_TURN = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      cmd,
  input  logic [7:0]      din,
  output logic            busy,
  output logic            done,
  output logic [RX_W-1:0] rd_data,
  output logic            rd_valid,
  spi_if.master           spi
);

  localparam logic [3:0] LastBit  = 4'(FRAME_W - 1);
  localparam logic [3:0] LastTurn = 4'(RD_TURN - 1);
  localparam logic [3:0] LastRecv = 4'(RX_W - 1);

  spi_state_e         state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [RX_W-1:0]    rd_data_q, rd_data_d;
  logic [RX_W-1:0]    rx_data;
  logic               rx_en, rx_clr;
  logic               ss_n, mosi;
  logic               is_rd;

  assign is_rd = (spi_cmd_e'(frame_q[FRAME_W-1 -: 2]) == RD_DATA);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    ss_n      = 1'b0;
    mosi      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    rd_valid  = 1'b0;
    rx_en     = 1'b0;
    rx_clr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        ss_n = 1'b1;
        busy = 1'b0;
        if (start) begin
          frame_d = {cmd, din};
          cnt_d   = '0;
          rx_clr  = 1'b1;
          state_d = StCmd;
        end
      end
      StCmd: begin
        mosi    = frame_q[FRAME_W-1];
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        mosi = frame_q[LastBit - cnt_q];
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHold: begin
        cnt_d = '0;
        if (!is_rd) begin
          state_d = StEnd;
        end else if (RD_TURN == 0) begin
          state_d = StRecv;
        end else begin
          state_d = StTurn;
        end
      end
      StTurn: begin
        if (cnt_q == LastTurn) begin
          cnt_d   = '0;
          state_d = StRecv;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRecv: begin
        rx_en = 1'b1;
        if (cnt_q == LastRecv) begin
          cnt_d   = '0;
          state_d = StEnd;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StEnd: begin
        ss_n     = 1'b1;
        done     = 1'b1;
        rd_valid = is_rd;
        if (is_rd) begin
          rd_data_d = rx_data;
        end
        state_d = StIdle;
      end
      default: begin
        ss_n    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  spi_rx_shift u_rx (
    .clk   (clk),
    .rst   (rst),
    .en_i  (rx_en),
    .clr_i (rx_clr),
    .miso_i(spi.MISO),
    .data_o(rx_data)
  );

  // The collector already holds the full byte during END, so present it in that same
  // cycle alongside rd_valid; the register keeps it afterwards.
  assign rd_data  = (state_q == StEnd && is_rd) ? rx_data : rd_data_q;
  assign spi.SS_n = ss_n;
  assign spi.MOSI = mosi;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with a behavioural SPI slave + RAM on the bus and a
// transaction-level reference model predicting frame shape and read results.
module tb_spi_master;

  localparam int unsigned RdTurn = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] din;
  logic       busy, done, rd_valid;
  logic [7:0] rd_data;

  spi_if bus ();

  spi_master #(.RD_TURN(RdTurn)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cmd     (cmd),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .spi     (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus monitor + SPI slave with RAM ----------------
  logic        mon_bits[$];
  int unsigned low_cnt = 0, hi_cnt = 0, last_gap = 0, fin_len = 0, frames = 0;
  logic [11:0] fin_head = '0;
  int          done_cnt = 0, rv_cnt = 0;
  logic [7:0]  slv_ram[256];
  logic [7:0]  slv_addr = '0;

  initial begin
    logic [1:0] c;
    logic [7:0] d;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) slv_ram[i] = '0;
    bus.MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.SS_n === 1'b0) begin
        if (hi_cnt != 0) begin
          last_gap = hi_cnt;
          hi_cnt   = 0;
        end
        // Drive read data LSB first for the cycles in which the master samples it.
        if (low_cnt >= 12 + RdTurn && low_cnt < 20 + RdTurn && mon_bits[1] && mon_bits[2]) begin
          b = slv_ram[slv_addr];
          bus.MISO = b[3'(low_cnt - 12 - RdTurn)];
        end else begin
          bus.MISO = 1'b0;
        end
        mon_bits.push_back(bus.MOSI);
        low_cnt++;
      end else begin
        hi_cnt++;
        bus.MISO = 1'b0;
        if (low_cnt != 0) begin
          fin_len = low_cnt;
          for (int j = 0; j < 12; j++) fin_head[11-j] = (j < int'(low_cnt)) ? mon_bits[j] : 1'b0;
          frames++;
          if (low_cnt >= 12) begin
            c = {mon_bits[1], mon_bits[2]};
            for (int j = 0; j < 8; j++) d[7-j] = mon_bits[3+j];
            if (c == 2'b00 || c == 2'b10) slv_addr = d;
            else if (c == 2'b01) slv_ram[slv_addr] = d;
          end
          mon_bits.delete();
          low_cnt = 0;
        end
      end
      if (done === 1'b1) done_cnt++;
      if (rd_valid === 1'b1) rv_cnt++;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_ram[256];
  logic [7:0] ref_addr = '0;
  logic [7:0] ref_rd = '0;

  task automatic ref_apply(input logic [1:0] c, input logic [7:0] d);
    case (c)
      2'b00, 2'b10: ref_addr = d;
      2'b01:        ref_ram[ref_addr] = d;
      default:      ref_rd = ref_ram[ref_addr];
    endcase
  endtask

  // Wait for the done pulse of a frame {c, d} and check everything about it.
  task automatic wait_check(input logic [1:0] c, input logic [7:0] d);
    bit          seen = 0;
    int          dc0 = done_cnt;
    int unsigned exp_len = (c == 2'b11) ? 20 + RdTurn : 12;
    logic [11:0] exp_head = {c[1], c, d, 1'b0};
    ref_apply(c, d);
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) seen = 1;
    end
    chk("done_seen", 32'(seen), 1);
    if (seen) begin
      chk("rd_valid_with_done", 32'(rd_valid), 32'(c == 2'b11));
      chk("busy_in_end", 32'(busy), 1);
      chk("ss_low_len", fin_len, exp_len);
      chk("mosi_bits", 32'(fin_head), 32'(exp_head));
      chk("rd_data_end", 32'(rd_data), 32'(ref_rd));
      chk("done_count", 32'(done_cnt - dc0), 1);
      @(negedge clk);
      #1;
      chk("done_one_cycle", 32'(done), 0);
      chk("busy_idle", 32'(busy), 0);
      chk("rd_data_hold", 32'(rd_data), 32'(ref_rd));
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d);
    @(negedge clk);
    cmd   = c;
    din   = d;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 1);
    wait_check(c, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr0, rv0, dc0;
    logic [1:0] c;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) ref_ram[i] = '0;
    // Reset with start held high: reset wins.
    rst = 1'b1; start = 1'b1; cmd = 2'b11; din = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ss_n", 32'(bus.SS_n), 1);
    chk("rst_mosi", 32'(bus.MOSI), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset on the 5th SHIFT cycle of a read-data frame aborts it.
    dc0 = done_cnt; rv0 = rv_cnt;
    @(negedge clk);
    cmd = 2'b11; din = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;                // CMD cycle
    repeat (5) @(negedge clk);   // SHIFT cycle 5
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ss_n", 32'(bus.SS_n), 1);
    chk("abort_busy", 32'(busy), 0);
    repeat (30) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - dc0), 0);
    chk("abort_no_rd_valid", 32'(rv_cnt - rv0), 0);
    chk("abort_rd_data", 32'(rd_data), 0);
    chk("abort_ss_len", fin_len, 6);

    // Directed frames.
    send(2'b00, 8'hA5);
    send(2'b10, 8'h3C);
    send(2'b00, 8'h00);
    send(2'b01, 8'h4D);
    send(2'b11, 8'h00);          // MISO 1,0,1,1,0,0,1,0 -> 0x4D
    chk("read_4d", 32'(rd_data), 32'h4D);

    // start pulsed mid-SHIFT with different cmd/din: frame unaffected, no extra frame.
    fr0 = frames;
    @(negedge clk);
    cmd = 2'b01; din = 8'h96; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    cmd = 2'b11; din = 8'h69; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_check(2'b01, 8'h96);
    repeat (25) @(negedge clk);
    #1;
    chk("no_second_frame", 32'(frames - fr0), 1);
    chk("idle_ss_n", 32'(bus.SS_n), 1);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 24; n++) begin
      c = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      send(c, d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // start held high: back-to-back frames through the slave RAM.
    @(negedge clk);
    cmd = 2'b00; din = 8'h55; start = 1'b1;
    wait_check(2'b00, 8'h55);
    cmd = 2'b01; din = 8'hC3;
    wait_check(2'b01, 8'hC3);
    chk("b2b_gap1", last_gap, 2);  // END plus the IDLE cycle that accepts the held start
    cmd = 2'b10; din = 8'h55;
    wait_check(2'b10, 8'h55);
    chk("b2b_gap2", last_gap, 2);
    cmd = 2'b11; din = 8'h00;
    wait_check(2'b11, 8'h00);
    start = 1'b0;
    chk("b2b_gap3", last_gap, 2);
    chk("b2b_read", 32'(rd_data), 32'hC3);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
